mem_stage: RTL



---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_lane_align.sv | 67 ++++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the memory-access stage.
// Holds the FSM state enum, the instruction-class code, the funct3 encodings and the branch condition helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [2:0] ITYPE_BRANCH = 3'd4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Encodings 110 and 111 are never taken.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic ltz);
    logic t;
    case (f3)
      F3_BEQ:  t = zero;
      F3_BNE:  t = ~zero;
      F3_BLT:  t = ltz;
      F3_BGE:  t = ~ltz;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the memory-access stage.
// The stage side connects through the master modport and the memory side through the slave modport.
interface mem_stage_if;
  logic        dmem_req_valid_o;
  logic        dmem_req_ready_i;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_be_o;
  logic        dmem_rsp_valid_i;
  logic [63:0] dmem_rdata_i;

  modport master (
    output dmem_req_valid_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_req_ready_i, dmem_rsp_valid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_valid_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_req_ready_i, dmem_rsp_valid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane logic: store enables and data shift, load extraction with extension, and fault detection.
// Purely combinational; access size comes from funct3[1:0].
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] ldata_o,
  output logic        fault_o
);

  logic [7:0]  mask;
  logic        misalign;
  logic        illegal;
  logic [5:0]  sh;
  logic [63:0] shifted;

  assign sh = {off_i, 3'b000};

  always_comb begin
    mask     = '0;
    misalign = 1'b0;
    case (funct3_i[1:0])
      2'b00: mask = 8'h01;
      2'b01: begin
        mask     = 8'h03;
        misalign = off_i[0];
      end
      2'b10: begin
        mask     = 8'h0F;
        misalign = |off_i[1:0];
      end
      default: begin
        mask     = 8'hFF;
        misalign = |off_i;
      end
    endcase
  end

  assign be_o    = mask << off_i;
  assign wdata_o = wdata_i << sh;
  assign shifted = rdata_i >> sh;

  always_comb begin
    ldata_o = '0;
    case (funct3_i)
      F3_LB:   ldata_o = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   ldata_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   ldata_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   ldata_o = shifted;
      F3_LBU:  ldata_o = {56'd0, shifted[7:0]};
      F3_LHU:  ldata_o = {48'd0, shifted[15:0]};
      F3_LWU:  ldata_o = {32'd0, shifted[31:0]};
      default: ldata_o = '0;
    endcase
  end

  assign illegal = (is_load_i && (funct3_i == F3_ILL)) || (is_store_i && funct3_i[2]);
  assign fault_o = (is_load_i | is_store_i) & (misalign | illegal);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage between the XM and MW pipeline registers: issues data-memory loads/stores,
// resolves conditional branches and hands write-back fields downstream over valid/ready.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned RspTimeout  = 0,
  parameter logic [2:0]  ITypeBranch = ITYPE_BRANCH
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               zero_i,
  input  logic               ltz_i,
  input  logic [63:0]        BranchPC_i,
  input  logic [63:0]        result_i,
  input  logic [63:0]        MuxRes_i,
  input  logic [4:0]         rd_i,
  input  logic               RegWrite_i,
  input  logic               MemWrite_i,
  input  logic               MemRead_i,
  input  logic               MemToReg_i,
  input  logic [2:0]         funct3_i,
  input  logic [2:0]         I_Type_i,
  mem_stage_if.master        dmem,
  output logic               branch_taken_o,
  output logic [63:0]        branch_target_o,
  output logic               fault_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [63:0]        ReadData_o,
  output logic [63:0]        result_o,
  output logic [4:0]         rd_o,
  output logic               RegWrite_o,
  output logic               MemToReg_o
);

  state_t      state_q;
  logic [63:0] result_q, muxres_q, readdata_q, target_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic        regwrite_q, memtoreg_q, load_q, store_q, taken_q, fault_q;
  logic [31:0] cnt_q;

  logic        accept, is_branch, in_load, in_store, use_in, req_active, timeout;
  logic [2:0]  al_off, al_f3;
  logic        al_load, al_store, al_fault;
  logic [63:0] al_wdata, al_wdata_sh, al_ldata;
  logic [7:0]  al_be;

  assign ready_o   = (state_q == S_IDLE) || ((state_q == S_OUT) && ready_i);
  assign accept    = valid_i && ready_o;
  assign is_branch = (I_Type_i == ITypeBranch);
  // A beat with both MemRead and MemWrite set is a load.
  assign in_load   = MemRead_i && !is_branch;
  assign in_store  = MemWrite_i && !MemRead_i && !is_branch;

  // The lane aligner sees the incoming beat while accepting (fault check)
  // and the captured beat while the access is in flight.
  assign use_in   = (state_q == S_IDLE) || (state_q == S_OUT);
  assign al_off   = use_in ? result_i[2:0] : result_q[2:0];
  assign al_f3    = use_in ? funct3_i      : funct3_q;
  assign al_load  = use_in ? in_load       : load_q;
  assign al_store = use_in ? in_store      : store_q;
  assign al_wdata = use_in ? MuxRes_i      : muxres_q;

  mem_lane_align u_align (
    .off_i     (al_off),
    .funct3_i  (al_f3),
    .is_load_i (al_load),
    .is_store_i(al_store),
    .wdata_i   (al_wdata),
    .rdata_i   (dmem.dmem_rdata_i),
    .be_o      (al_be),
    .wdata_o   (al_wdata_sh),
    .ldata_o   (al_ldata),
    .fault_o   (al_fault)
  );

  assign req_active            = (state_q == S_REQ);
  assign dmem.dmem_req_valid_o = req_active;
  assign dmem.dmem_we_o        = req_active && store_q;
  assign dmem.dmem_addr_o      = req_active ? {result_q[63:3], 3'b000} : '0;
  assign dmem.dmem_be_o        = req_active ? al_be : '0;
  assign dmem.dmem_wdata_o     = req_active ? al_wdata_sh : '0;

  assign timeout = (RspTimeout != 0) && (cnt_q == RspTimeout - 1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      muxres_q   <= '0;
      readdata_q <= '0;
      target_q   <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      taken_q    <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      taken_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OUT: begin
          if (accept) begin
            result_q   <= result_i;
            muxres_q   <= MuxRes_i;
            readdata_q <= '0;
            rd_q       <= rd_i;
            funct3_q   <= funct3_i;
            regwrite_q <= RegWrite_i && !al_fault;
            memtoreg_q <= MemToReg_i;
            load_q     <= in_load;
            store_q    <= in_store;
            fault_q    <= al_fault;
            cnt_q      <= '0;
            if (is_branch) begin
              taken_q  <= branch_taken(funct3_i, zero_i, ltz_i);
              target_q <= BranchPC_i;
            end
            state_q <= ((in_load || in_store) && !al_fault) ? S_REQ : S_OUT;
          end else if (state_q == S_OUT && ready_i) begin
            state_q <= S_IDLE;
          end
        end
        S_REQ: begin
          if (dmem.dmem_req_ready_i) state_q <= store_q ? S_OUT : S_WAIT;
        end
        S_WAIT: begin
          if (dmem.dmem_rsp_valid_i) begin
            readdata_q <= al_ldata;
            state_q    <= S_OUT;
          end else if (timeout) begin
            fault_q    <= 1'b1;
            regwrite_q <= 1'b0;
            state_q    <= S_OUT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign valid_o         = (state_q == S_OUT);
  assign branch_taken_o  = taken_q;
  assign branch_target_o = target_q;
  assign fault_o         = fault_q;
  assign ReadData_o      = readdata_q;
  assign result_o        = result_q;
  assign rd_o            = rd_q;
  assign RegWrite_o      = regwrite_q;
  assign MemToReg_o      = memtoreg_q;

endmodule
